// File: rtl/cnn_sched_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cnn_sched_pkg : shared states, error codes and defaults for the scheduler |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
package cnn_sched_pkg;

    localparam int FRAME_PIXELS_DEFAULT = 784;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STREAM   = 3'd1,
        PAD      = 3'd2,
        FLUSH    = 3'd3,
        WAIT_RES = 3'd4,
        HOLD     = 3'd5
    } sched_state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_SHORT   = 2'd1;
    localparam logic [1:0] ERR_LONG    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cnn_frame_scheduler_watchdog.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sched_watchdog : saturating result-wait counter, expired at the limit     |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/cnn_frame_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cnn_frame_scheduler : exact-length frame admission and result handoff     |
// | Optional: CNN_SCHED_PERF_EN builds the latency counter.   Revision 1.0    |
// +---------------------------------------------------------------------------+
module cnn_frame_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int FRAME_PIXELS   = FRAME_PIXELS_DEFAULT,
    parameter int DATA_W         = 8,
    parameter int CLASS_W        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [DATA_W-1:0]  core_data,
    output logic               core_valid,
    input  logic               core_busy,
    input  logic [CLASS_W-1:0] core_decision,
    input  logic               core_valid_out,
    output logic [CLASS_W-1:0] res_class,
    output logic [1:0]         res_err,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy,
    output logic [15:0]        frame_count,
    output logic [15:0]        latency_cycles
);

    localparam int PIX_W = $clog2(FRAME_PIXELS);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIXELS - 1);

    sched_state_t     state;
    sched_state_t     next_state;
    logic [PIX_W-1:0] pix_count;
    logic             captured;
    logic             expired;
    logic             beat;

    assign beat = s_valid & s_ready;

    sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .enable (state == WAIT_RES),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        busy       = 1'b1;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!core_busy) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (pix_count == LAST_PIX) begin
                        next_state = s_last ? WAIT_RES : FLUSH;
                    end else if (s_last) begin
                        next_state = PAD;
                    end
                end
            end
            PAD: begin
                if (pix_count == LAST_PIX) begin
                    next_state = WAIT_RES;
                end
            end
            FLUSH: begin
                s_ready = 1'b1;
                // A decision that already arrived during the flush skips WAIT_RES.
                if (s_valid && s_last) begin
                    next_state = (captured || core_valid_out) ? HOLD : WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (core_valid_out || expired) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_data   <= '0;
            core_valid  <= 1'b0;
            pix_count   <= '0;
            res_class   <= '0;
            res_err     <= ERR_OK;
            captured    <= 1'b0;
            frame_count <= '0;
        end else begin
            core_valid <= 1'b0;
            case (state)
                IDLE: begin
                    pix_count <= '0;
                    res_err   <= ERR_OK;
                    res_class <= '0;
                    captured  <= 1'b0;
                end
                STREAM: begin
                    if (beat) begin
                        core_data  <= s_data;
                        core_valid <= 1'b1;
                        pix_count  <= pix_count + 1'b1;
                        if (pix_count == LAST_PIX) begin
                            res_err <= s_last ? ERR_OK : ERR_LONG;
                        end else if (s_last) begin
                            res_err <= ERR_SHORT;
                        end
                    end
                end
                PAD: begin
                    core_data  <= '0;
                    core_valid <= 1'b1;
                    pix_count  <= pix_count + 1'b1;
                end
                FLUSH: begin
                    if (core_valid_out && !captured) begin
                        res_class <= core_decision;
                        captured  <= 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (core_valid_out) begin
                        res_class <= core_decision;
                    end else if (expired) begin
                        res_class <= '1;
                        res_err   <= ERR_TIMEOUT;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        frame_count <= frame_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CNN_SCHED_PERF_EN
    logic        lat_run;
    logic        lat_stop;
    logic [15:0] lat_count;
    logic        capture_evt;

    assign capture_evt = ((state == FLUSH) && core_valid_out && !captured) ||
                         ((state == WAIT_RES) && (core_valid_out || expired));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_run   <= 1'b0;
            lat_stop  <= 1'b0;
            lat_count <= '0;
        end else if (state == IDLE) begin
            lat_run   <= 1'b0;
            lat_stop  <= 1'b0;
            lat_count <= '0;
        end else begin
            if (core_valid) begin
                lat_run <= 1'b1;
            end
            if (capture_evt) begin
                lat_stop <= 1'b1;
            end
            if ((core_valid || lat_run) && !lat_stop && (state != HOLD) &&
                (lat_count != 16'hFFFF)) begin
                lat_count <= lat_count + 16'd1;
            end
        end
    end

    assign latency_cycles = lat_count;
`else
    assign latency_cycles = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/cnn_frame_scheduler.md
# cnn_frame_scheduler

Frame-level controller between the upstream pixel source and the `cnn_top_opt` inference core. Admits one 784-pixel frame at a time under a valid/ready handshake and forwards it to the core. Enforces the exact frame length: short frames are zero-padded, long frames are truncated and flushed. Waits for the core's decision under a watchdog and holds the result until the consumer accepts it.

## Interface
- `FRAME_PIXELS`, 784, pixels per frame sent to the core.
- `DATA_W`, 8, pixel width.
- `CLASS_W`, 4, decision width.
- `TIMEOUT_CYCLES`, 4096, maximum cycles in WAIT_RES before a timeout is declared.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data`  in  DATA_W  upstream pixel.
- `s_valid`  in  1  upstream pixel valid.
- `s_last`  in  1  marks the last pixel of the upstream frame.
- `s_ready`  out  1  scheduler accepts a pixel.
- `core_data`  out  DATA_W  pixel to the core (`data_in`).
- `core_valid`  out  1  pixel strobe to the core (`valid_in`).
- `core_busy`  in  1  core `busy`.
- `core_decision`  in  CLASS_W  core `decision`.
- `core_valid_out`  in  1  core `valid_out`.
- `res_class`  out  CLASS_W  captured decision.
- `res_err`  out  2  error code: 0 OK, 1 SHORT, 2 LONG, 3 TIMEOUT.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in any state except IDLE.
- `frame_count`  out  16  count of results handed off; wraps at 2^16.
- `latency_cycles`  out  16  cycles from the first pixel sent to the result being captured (see Configuration).

## Operation
- FSM states: IDLE, STREAM, PAD, FLUSH, WAIT_RES, HOLD.
- IDLE:
  - `s_ready` = 0.
  - Go to STREAM when `core_busy` = 0 and `res_valid` = 0.
  - Clear the pixel counter, error register and timeout counter.
- STREAM:
  - `s_ready` = 1. A beat is `s_valid & s_ready`.
  - Each beat registers `s_data` to `core_data` with `core_valid` = 1. Otherwise `core_valid` = 0; the core tolerates gaps.
  - The pixel counter increments per beat.
  - Beat at count = FRAME_PIXELS-1 with `s_last` = 1: go to WAIT_RES, err = OK.
  - Beat at count = FRAME_PIXELS-1 with `s_last` = 0: go to FLUSH, err = LONG.
  - Beat with `s_last` = 1 at count < FRAME_PIXELS-1: go to PAD, err = SHORT.
- PAD:
  - `s_ready` = 0.
  - Drive `core_valid` = 1, `core_data` = 0 every cycle until FRAME_PIXELS pixels total have been sent, then go to WAIT_RES.
- FLUSH:
  - `s_ready` = 1, `core_valid` = 0. Upstream beats are discarded.
  - A beat with `s_last` = 1 goes to WAIT_RES.
  - The core already has its full frame, so FLUSH must not block it. The result is captured in FLUSH as in WAIT_RES, and the FSM holds the result until flush completes.
- WAIT_RES:
  - The timeout counter increments each cycle.
  - `core_valid_out` = 1: capture `core_decision`, go to HOLD.
  - Counter reaches TIMEOUT_CYCLES: `res_class` = all ones, err = TIMEOUT, go to HOLD.
  - If both occur in the same cycle, `core_valid_out` wins.
- HOLD:
  - `res_valid` = 1, with `res_class` and `res_err` stable.
  - On `res_valid & res_ready`: `frame_count` += 1, go to IDLE.
- `core_valid_out` outside WAIT_RES/FLUSH is ignored.
- Arithmetic: the pixel counter is clog2(FRAME_PIXELS) bits; the timeout counter is clog2(TIMEOUT_CYCLES+1) bits and saturates.

## Timing
- Reset is asynchronous: all outputs go to 0 immediately and the FSM goes to IDLE, including mid-frame. `core_valid` drops in the same cycle as `rst`.
- Pixel path latency: a beat accepted at edge N appears on `core_data`/`core_valid` during cycle N+1.
- IDLE→STREAM takes one cycle. The first beat is accepted at the earliest on the edge after STREAM is entered.
- `res_valid` rises on the edge after `core_valid_out` is sampled.
- Timeout: `res_valid` rises TIMEOUT_CYCLES+1 edges after WAIT_RES is entered.
- `res_ready` may be held high in advance; the handoff completes in the first HOLD cycle, and IDLE follows.
- Single-pixel frame (`s_last` on the first beat): PAD runs FRAME_PIXELS-1 cycles.

## Configuration
- `CNN_SCHED_PERF_EN` defined: `latency_cycles` counts from the first `core_valid` cycle of a frame until result capture. It saturates at 0xFFFF and is held through HOLD.
- Not defined: `latency_cycles` is tied to 0 and no counter logic is built.

## Structure
- Package `cnn_sched_pkg`: FSM state enum, error code constants (ERR_OK/SHORT/LONG/TIMEOUT) and the default FRAME_PIXELS.
- One sub-module, `sched_watchdog`: the saturating timeout counter with clear/enable inputs and an `expired` output.

## Test plan
- Exactly 784 pixels streamed back-to-back (value i%16), `s_last` on pixel 783, core returns 7 → `res_class` = 7, `res_err` = 0, `frame_count` = 1.
- `s_last` on pixel 99 → 684 cycles of `core_valid` = 1 with `core_data` = 0, total 784 core strobes, `res_err` = 1.
- 800 pixels sent → 784 forwarded, 16 dropped while `s_ready` = 1, `res_err` = 2.
- Core never asserts `valid_out`, TIMEOUT_CYCLES = 64 → `res_valid` 65 edges after WAIT_RES entry, `res_class` = 0xF, `res_err` = 3.
- `rst` pulsed at pixel 400 → `core_valid` and `busy` = 0 immediately. The next frame restarts from pixel 0 and completes OK.
- Random `s_valid` gaps plus `res_ready` held low for 20 cycles → no pixel lost or duplicated, and the result stays stable throughout HOLD.
